// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_pkg
// Purpose  : Shared types and constants for the FIFO-fed UART transmitter.
//            tx_state_t  - transmitter state encoding
//            IDLE_LEVEL  - serial line level when idle / stop bit
//            START_LEVEL - serial line level of the start bit
// Revision : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps.
// Ports    : clk     - rising-edge clock
//            rst     - synchronous reset, active-low
//            clear   - forces the counter to 0 on the next edge
//            bit_end - high in the last cycle of a bit period
//            pre_end - high in the second-to-last cycle of a bit period
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end,
    output logic pre_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);
    assign pre_end = (cnt_q == CNT_PRE);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops words from a synchronous FIFO and serialises each one as a
//            UART frame: start bit, data LSB-first, optional even parity,
//            STOP_BITS stop bits. Pops are spaced at least 3 cycles apart.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous reset, active-low
//            tx_en      - permits a new frame (sampled only in IDLE)
//            fifo_empty - FIFO empty flag (sampled only in IDLE)
//            fifo_data  - FIFO read data, valid the cycle after fifo_rd_en
//            fifo_rd_en - single-cycle pop request
//            tx         - serial output, idles high
//            busy       - high whenever not IDLE
//            frame_done - pulse in the last cycle of the final stop bit
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              fifo_rd_en_q, fifo_rd_en_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              bit_end;
    logic              pre_end;
    logic              baud_clear;

    // Bit periods only run in the serialising states; everywhere else, and on
    // every state change, the counter is held at zero so each state starts on
    // a fresh bit period.
    assign baud_clear = (state_d != state_q) ||
                        (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_end (bit_end),
        .pre_end (pre_end)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_q         <= IDLE_LEVEL;
            fifo_rd_en_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state, bit counting, shift register and parity
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d  = fifo_data;
                parity_d = ^fifo_data;
                state_d  = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // The bit counter is reused to count stop bits.
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they belong to.
    always_comb begin
        tx_d         = IDLE_LEVEL;
        fifo_rd_en_d = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        case (state_d)
            ST_FETCH:  fifo_rd_en_d = 1'b1;
            ST_START:  tx_d = START_LEVEL;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = IDLE_LEVEL;
        endcase
        // One cycle early, so the registered pulse lands in the final cycle.
        frame_done_d = (state_q == ST_STOP) && (bit_cnt_q == LAST_STOP) && pre_end;
    end

    assign tx         = tx_q;
    assign fifo_rd_en = fifo_rd_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx. Three instances cover the
//            default frame, even parity and two stop bits. A queue-based FIFO
//            model feeds each instance; expected line levels come from the
//            frame layout (start, data LSB-first, parity, stops).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int ND   = 3;
    localparam int CLKS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [ND-1:0]   tx_en_v;
    logic [ND-1:0]   empty_v;
    logic [7:0]      fdata [ND];
    wire  [ND-1:0]   rd_v;
    wire  [ND-1:0]   tx_v;
    wire  [ND-1:0]   busy_v;
    wire  [ND-1:0]   done_v;

    int par_en [ND] = '{0, 1, 0};
    int stop_n [ND] = '{1, 1, 2};

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en_v[0]), .fifo_empty(empty_v[0]),
        .fifo_data(fdata[0]), .fifo_rd_en(rd_v[0]), .tx(tx_v[0]),
        .busy(busy_v[0]), .frame_done(done_v[0]));

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en_v[1]), .fifo_empty(empty_v[1]),
        .fifo_data(fdata[1]), .fifo_rd_en(rd_v[1]), .tx(tx_v[1]),
        .busy(busy_v[1]), .frame_done(done_v[1]));

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en_v[2]), .fifo_empty(empty_v[2]),
        .fifo_data(fdata[2]), .fifo_rd_en(rd_v[2]), .tx(tx_v[2]),
        .busy(busy_v[2]), .frame_done(done_v[2]));

    int checks    = 0;
    int passes    = 0;
    int underflow = 0;
    int cyc       = 0;
    logic [ND-1:0] pend;
    logic [7:0] fq0[$], fq1[$], fq2[$];
    logic [7:0] wl[$];

    function automatic int qsize(input int d);
        case (d)
            0:       return fq0.size();
            1:       return fq1.size();
            default: return fq2.size();
        endcase
    endfunction

    function automatic logic [7:0] qpop(input int d);
        case (d)
            0:       return fq0.pop_front();
            1:       return fq1.pop_front();
            default: return fq2.pop_front();
        endcase
    endfunction

    task automatic qpush(input int d, input logic [7:0] w);
        case (d)
            0:       fq0.push_back(w);
            1:       fq1.push_back(w);
            default: fq2.push_back(w);
        endcase
        empty_v[d] = 1'b0;
    endtask

    // Line level of serial bit b of a frame carrying w.
    function automatic logic exp_level(input int d, input logic [7:0] w, input int b);
        int ones = 0;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (b == 9 && par_en[d] != 0) begin
            for (int i = 0; i < 8; i++) ones += int'(w[i]);
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Advance one cycle. The FIFO model pops on the edge that sees fifo_rd_en,
    // so data appears the cycle after the request. Outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            if (pend[d]) begin
                pend[d] = 1'b0;
                if (qsize(d) == 0) underflow++;
                else fdata[d] = qpop(d);
                empty_v[d] = (qsize(d) == 0);
            end
        end
        @(negedge clk);
        cyc++;
        for (int d = 0; d < ND; d++) begin
            if (rd_v[d]) pend[d] = 1'b1;
        end
    endtask

    task automatic wait_pop(input int d, input int budget, output int t);
        int n = 0;
        while (!rd_v[d] && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("d%0d pop_seen", d), {31'd0, rd_v[d]}, 32'd1);
        t = cyc;
    endtask

    // Called in the cycle fifo_rd_en is high; checks the whole frame.
    task automatic frame_check(input int d, input logic [7:0] w);
        int n;
        n = (9 + par_en[d] + stop_n[d]) * CLKS;
        tick();
        chk($sformatf("d%0d w%02h load", d, w),
            {28'd0, rd_v[d], tx_v[d], busy_v[d], done_v[d]}, 32'b0110);
        for (int k = 0; k < n; k++) begin
            tick();
            chk($sformatf("d%0d w%02h c%0d {rd,tx,busy,done}", d, w, k + 2),
                {28'd0, rd_v[d], tx_v[d], busy_v[d], done_v[d]},
                {28'd0, 1'b0, exp_level(d, w, k / CLKS), 1'b1, (k == n - 1)});
        end
        tick();
        chk($sformatf("d%0d w%02h post", d, w),
            {28'd0, rd_v[d], tx_v[d], busy_v[d], done_v[d]}, 32'b0100);
    endtask

    task automatic idle_check(input int d, input int n, input string tag);
        logic ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rd_v[d] !== 1'b0 || tx_v[d] !== 1'b1 || busy_v[d] !== 1'b0) ok = 1'b0;
        end
        chk($sformatf("d%0d %s", d, tag), {31'd0, ok}, 32'd1);
    endtask

    // Queue every word in wl, then check each frame and the pop spacing.
    task automatic burst(input int d);
        int t_prev = 0;
        int t_now  = 0;
        int bits;
        bits = 9 + par_en[d] + stop_n[d];
        foreach (wl[i]) qpush(d, wl[i]);
        for (int i = 0; i < wl.size(); i++) begin
            wait_pop(d, 60, t_now);
            if (i > 0) chk($sformatf("d%0d spacing%0d", d, i), t_now - t_prev, bits * CLKS + 3);
            frame_check(d, wl[i]);
            t_prev = t_now;
        end
        idle_check(d, 10, "idle_after_burst");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] w1, w2;
        rst = 1'b0;
        tx_en_v = '0;
        empty_v = '1;
        pend = '0;
        for (int d = 0; d < ND; d++) fdata[d] = 8'h00;
        repeat (3) tick();
        for (int d = 0; d < ND; d++)
            chk($sformatf("d%0d reset", d),
                {28'd0, rd_v[d], tx_v[d], busy_v[d], done_v[d]}, 32'b0100);
        rst = 1'b1;
        tick();

        // Single word
        tx_en_v[0] = 1'b1;
        wl = '{8'hA5};
        burst(0);

        // Back-to-back preload
        wl = '{8'h01, 8'h80, 8'hFF};
        burst(0);

        // Random words
        wl = {};
        for (int i = 0; i < 4; i++) wl.push_back(8'($urandom));
        burst(0);

        // Parity
        tx_en_v[1] = 1'b1;
        wl = '{8'hA5, 8'h07, 8'($urandom)};
        burst(1);

        // Two stop bits
        tx_en_v[2] = 1'b1;
        wl = '{8'h3C, 8'($urandom)};
        burst(2);

        // Flow control: FIFO non-empty but tx_en low
        tx_en_v[0] = 1'b0;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        qpush(0, w1);
        idle_check(0, 100, "held_by_tx_en");
        tx_en_v[0] = 1'b1;
        tick();
        chk("d0 pop_after_tx_en", {31'd0, rd_v[0]}, 32'd1);
        // Drop tx_en mid-frame: frame completes, next word waits.
        qpush(0, w2);
        tx_en_v[0] = 1'b0;
        frame_check(0, w1);
        idle_check(0, 30, "wait_after_tx_en_drop");
        tx_en_v[0] = 1'b1;
        wait_pop(0, 10, t);
        frame_check(0, w2);

        // Reset in the middle of data bit 4
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        qpush(0, w1);
        qpush(0, w2);
        wait_pop(0, 10, t);
        repeat (22) tick();
        chk("d0 pre_reset_bit4", {31'd0, tx_v[0]}, {31'd0, w1[4]});
        rst = 1'b0;
        tick();
        chk("d0 mid_frame_reset",
            {28'd0, rd_v[0], tx_v[0], busy_v[0], done_v[0]}, 32'b0100);
        rst = 1'b1;
        wait_pop(0, 10, t);
        frame_check(0, w2);
        idle_check(0, 10, "no_reread");
        chk("d0 queue_drained", qsize(0), 32'd0);

        chk("underflow", underflow, 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the team's synchronous FIFO. It pops one word at a time from the FIFO and serialises it as an asynchronous UART frame: start bit, data LSB-first, optional even parity, then stop bit(s). It sits between the FIFO read side and the chip's serial TX pin, and paces FIFO reads so it never outruns the FIFO's status flags.

Parameters:
- DATA_W, 8, bits per data word; must equal the FIFO width.
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be ≥2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (rst==0 resets on the next clk edge)
- tx_en  input  1  permits a new frame to start; sampled only in IDLE
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  DATA_W  FIFO data_out; valid the cycle after fifo_rd_en
- fifo_rd_en  output  1  single-cycle pop request to the FIFO
- tx  output  1  serial line; idles high
- busy  output  1  high whenever state != IDLE
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- All outputs are registered. Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, bit counter=0, baud counter=0.
- State machine: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If tx_en && !fifo_empty, go to FETCH; otherwise stay.
- FETCH: exactly one cycle with fifo_rd_en=1, then go to LOAD. fifo_rd_en is never high in any other state.
- LOAD: one cycle. Capture fifo_data into the shift register; compute parity = XOR of the word. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_W bits, LSB first, each held for CLKS_PER_BIT cycles. Shift right at each bit boundary.
- PARITY: entered only if PARITY_EN. tx=parity for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 in the final cycle. Go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps at the bit boundary, and is cleared on every state entry. Width is $clog2(CLKS_PER_BIT).
- Bit counter: counts 0..DATA_W-1 and is width $clog2(DATA_W+1).
- Latency: fifo_rd_en is high in cycle t; tx falls at t+2. Without parity and with 1 stop bit, the frame occupies t+2..t+41.
- Back-to-back words: the next fifo_rd_en comes no earlier than t+43 (IDLE is always visited for one cycle). This ≥3-cycle spacing between pops is mandatory, because the FIFO's empty flag can lag its true occupancy by up to two cycles.
- fifo_empty is sampled only in IDLE. A change mid-frame has no effect.
- tx_en deassertion mid-frame: the current frame completes; the block then waits in IDLE.
- Reset mid-frame: on the next edge, tx=1 and all outputs take reset values. A word already popped is discarded, with no re-read.
- No FIFO pop occurs while rst==0.

Decomposition:
- Shared package fifo_uart_pkg: state enum (tx_state_t), IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- One natural sub-module: baud_tick_gen. It is a CLKS_PER_BIT counter with a clear input and a bit_end output. The FSM, shift register and parity logic stay in the top level.

Test Plan:
- Single word: push 0xA5, PARITY_EN=0, STOP_BITS=1 -> one fifo_rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame_done at t+41; busy low at t+42.
- Parity: PARITY_EN=1, words 0xA5 then 0x07 -> parity bits 0 then 1; frame length 44 cycles each.
- Back-to-back: preload 3 words (0x01, 0x80, 0xFF), tx_en=1 -> fifo_rd_en pulses at t, t+43, t+86; FIFO never underflows; tx stays high after the third frame.
- Flow control: tx_en=0 with FIFO non-empty -> no fifo_rd_en and tx=1 for 100 cycles; raising tx_en gives fifo_rd_en in the 2nd cycle after tx_en is sampled.
- STOP_BITS=2: send 0x3C -> stop segment is 8 cycles high; next pop 47 cycles after the previous one.
- Reset mid-DATA: drive rst=0 at bit 4 -> tx=1, busy=0, fifo_rd_en=0 the next cycle; after release, the next queued word is sent as a complete frame.
